// File: rtl/signal_phase_arbiter_if.sv
// Lamp and sensor bundle for the four-approach signal phase arbiter.
// master drives the car sensors; slave (the arbiter) drives the lamps and phase.
interface signal_phase_arbiter_if;
  logic [3:0] req;
  logic [3:0] green;
  logic [3:0] amber;
  logic [3:0] red;
  logic [1:0] phase;

  modport master (output req, input green, amber, red, phase);
  modport slave  (input req, output green, amber, red, phase);
endinterface

// File: rtl/signal_phase_arbiter.sv
// Four-approach traffic signal arbiter: ALL_RED -> GREEN -> AMBER with a 60 Hz time base.
// Optional macro REST_CYCLE_EN: an idle green also exits after the minimum time (round-robin rest cycling).
//
// state   | meaning
// ALL_RED | clearance interval; the winner is chosen on its last cycle
// GREEN   | approach 'phase' has right of way
// AMBER   | approach 'phase' is clearing
module signal_phase_arbiter #(
  parameter int TICKS_PER_SEC = 60,
  parameter int GREEN_MIN     = 12,
  parameter int MAX_GREEN     = 24,
  parameter int AMBER_TIME    = 3,
  parameter int CLEAR_TIME    = 6
) (
  input logic clk,
  input logic rst,
  signal_phase_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ALL_RED, GREEN, AMBER} state_t;

  localparam int SEC_MAX0 = (MAX_GREEN > GREEN_MIN) ? MAX_GREEN : GREEN_MIN;
  localparam int SEC_MAX1 = (SEC_MAX0 > AMBER_TIME) ? SEC_MAX0 : AMBER_TIME;
  localparam int SEC_MAX  = (SEC_MAX1 > CLEAR_TIME) ? SEC_MAX1 : CLEAR_TIME;
  localparam int SW       = $clog2(SEC_MAX + 1);
  localparam int PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  state_t        state, state_nx;
  logic [1:0]    phase_r, phase_nx, winner;
  logic [PW-1:0] presc;
  logic [SW-1:0] sec;
  logic [3:0]    green_r, amber_r, red_r, green_nx, amber_nx;
  logic          clr, own, other, min_ok, max_ok, go;

  // True once n seconds' worth of cycles, counting the current one, have elapsed in the state.
  function automatic logic elapsed_ge(input logic [SW-1:0] s, input logic [PW-1:0] p,
                                      input int n);
    return (int'(s) >= n) || ((int'(s) == n - 1) && (int'(p) == TICKS_PER_SEC - 1));
  endfunction

  always_comb begin
    state_nx = state;
    phase_nx = phase_r;
    clr      = 1'b0;
    own      = bus.req[phase_r];
    other    = |(bus.req & ~(4'b0001 << phase_r));
    min_ok   = elapsed_ge(sec, presc, GREEN_MIN);
    max_ok   = elapsed_ge(sec, presc, MAX_GREEN);
`ifdef REST_CYCLE_EN
    go       = (min_ok && !own) || (other && max_ok);
`else
    go       = other && ((min_ok && !own) || max_ok);
`endif
    // Descending scan so the nearest requester after phase wins; offset 4 wraps to phase itself.
    winner   = phase_r + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[phase_r + 2'(k)]) winner = phase_r + 2'(k);
    end
    case (state)
      ALL_RED: if (elapsed_ge(sec, presc, CLEAR_TIME)) begin
        state_nx = GREEN;
        phase_nx = winner;
        clr      = 1'b1;
      end
      GREEN: if (go) begin
        state_nx = AMBER;
        clr      = 1'b1;
      end
      AMBER: if (elapsed_ge(sec, presc, AMBER_TIME)) begin
        state_nx = ALL_RED;
        clr      = 1'b1;
      end
      default: begin
        state_nx = ALL_RED;
        clr      = 1'b1;
      end
    endcase
    green_nx = (state_nx == GREEN) ? (4'b0001 << phase_nx) : 4'b0000;
    amber_nx = (state_nx == AMBER) ? (4'b0001 << phase_nx) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ALL_RED;
      phase_r <= 2'd3;
      presc   <= '0;
      sec     <= '0;
      green_r <= 4'b0000;
      amber_r <= 4'b0000;
      red_r   <= 4'b1111;
    end else begin
      state   <= state_nx;
      phase_r <= phase_nx;
      green_r <= green_nx;
      amber_r <= amber_nx;
      red_r   <= ~(green_nx | amber_nx);
      if (clr) begin
        presc <= '0;
        sec   <= '0;
      end else if (presc == PW'(TICKS_PER_SEC - 1)) begin
        presc <= '0;
        if (sec < SW'(SEC_MAX)) sec <= sec + SW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign bus.green = green_r;
  assign bus.amber = amber_r;
  assign bus.red   = red_r;
  assign bus.phase = phase_r;

endmodule

// File: tb/tb_signal_phase_arbiter.sv
// Self-checking bench for signal_phase_arbiter against a cycle-count reference model.
// Honours REST_CYCLE_EN the same way the design does.
module tb_signal_phase_arbiter;
  localparam int TPS = 2, GMIN = 3, GMAX = 5, AMB = 1, CLR = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  signal_phase_arbiter_if bus ();

  signal_phase_arbiter #(
    .TICKS_PER_SEC(TPS), .GREEN_MIN(GMIN), .MAX_GREEN(GMAX),
    .AMBER_TIME(AMB), .CLEAR_TIME(CLR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = all red, 1 = green, 2 = amber; m_el = cycles completed in mode.
  int m_mode, m_ph, m_el;

  function automatic void model_reset();
    m_mode = 0; m_ph = 3; m_el = 0;
  endfunction

  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(m_ph + k) % 4]) return (m_ph + k) % 4;
    end
    return (m_ph + 1) % 4;
  endfunction

  function automatic void model_tick(input logic [3:0] r);
    int  n;
    bit  other, own, ext;
    n     = m_el + 1;
    own   = r[m_ph];
    other = 1'b0;
    for (int j = 0; j < 4; j++) if (j != m_ph && r[j]) other = 1'b1;
    if (m_mode == 0) begin
      if (n >= CLR * TPS) begin m_ph = pick(r); m_mode = 1; m_el = 0; end
      else m_el = n;
    end else if (m_mode == 1) begin
`ifdef REST_CYCLE_EN
      ext = (n >= GMIN * TPS && !own) || (other && n >= GMAX * TPS);
`else
      ext = other && ((n >= GMIN * TPS && !own) || n >= GMAX * TPS);
`endif
      if (ext) begin m_mode = 2; m_el = 0; end
      else m_el = n;
    end else begin
      if (n >= AMB * TPS) begin m_mode = 0; m_el = 0; end
      else m_el = n;
    end
  endfunction

  function automatic logic [13:0] model_out();
    logic [3:0] g, a;
    g = (m_mode == 1) ? (4'b0001 << m_ph) : 4'b0000;
    a = (m_mode == 2) ? (4'b0001 << m_ph) : 4'b0000;
    return {g, a, ~(g | a), 2'(m_ph)};
  endfunction

  function automatic logic [13:0] dut_out();
    return {bus.green, bus.amber, bus.red, bus.phase};
  endfunction

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    bus.req = r;
    @(posedge clk);
    if (rst) model_tick(r);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // which: 0 = green on, 1 = amber on, 2 = all red; counts the visible cycle plus further steps.
  task automatic run_while(input logic [3:0] r, input int which, output int cnt);
    bit cond;
    cnt = 0;
    forever begin
      cond = (which == 0) ? (bus.green != 0) :
             (which == 1) ? (bus.amber != 0) : (bus.green == 0 && bus.amber == 0);
      if (!cond || cnt >= 100) break;
      cnt++;
      step(r);
    end
  endtask

  task automatic test_reset();
    bus.req = 4'b0000;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (dut_out() !== {4'b0000, 4'b0000, 4'b1111, 2'd3}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dut_out(), {4'b0000, 4'b0000, 4'b1111, 2'd3});
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_idle_hold();
    step(4'b0000);
    checks++;
    if (bus.red !== 4'b1111 || bus.green !== 4'b0000) begin
      errors++;
      $display("FAIL idle_first_red: got red=%b green=%b expected red=1111 green=0000", bus.red, bus.green);
    end
    step(4'b0000);
    checks++;
    if (bus.green !== 4'b0001 || bus.phase !== 2'd0) begin
      errors++;
      $display("FAIL idle_first_grant: got green=%b phase=%0d expected green=0001 phase=0", bus.green, bus.phase);
    end
    for (int i = 0; i < 30; i++) begin
      step(4'b0000);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL idle_model cyc%0d: got %h expected %h", i, dut_out(), model_out());
      end
`ifndef REST_CYCLE_EN
      checks++;
      if (bus.green !== 4'b0001) begin
        errors++;
        $display("FAIL idle_hold cyc%0d: got green=%b expected 0001", i, bus.green);
      end
`endif
    end
  endtask

  task automatic test_min_green();
    int n;
    do_reset();
    step(4'b0000);
    step(4'b0000);
    run_while(4'b0100, 0, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL min_green_len: got %0d expected 6", n); end
    checks++;
    if (bus.amber !== 4'b0001) begin errors++; $display("FAIL min_amber_lamp: got %b expected 0001", bus.amber); end
    run_while(4'b0100, 1, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL min_amber_len: got %0d expected 2", n); end
    run_while(4'b0100, 2, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL min_clear_len: got %0d expected 2", n); end
    checks++;
    if (bus.green !== 4'b0100) begin errors++; $display("FAIL min_next_grant: got %b expected 0100", bus.green); end
  endtask

  task automatic test_rotation_max_green();
    int n;
    do_reset();
    step(4'b0000);
    step(4'b0100);
    checks++;
    if (bus.green !== 4'b0100) begin errors++; $display("FAIL rot_setup: got %b expected 0100", bus.green); end
    run_while(4'b0011, 0, n);
    run_while(4'b0011, 1, n);
    run_while(4'b0011, 2, n);
    checks++;
    if (bus.green !== 4'b0001) begin errors++; $display("FAIL rot_wrap_grant: got %b expected 0001", bus.green); end
    run_while(4'b0011, 0, n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL max_green_len: got %0d expected 10", n); end
    checks++;
    if (bus.amber !== 4'b0001) begin errors++; $display("FAIL max_amber_lamp: got %b expected 0001", bus.amber); end
    run_while(4'b0011, 1, n);
    run_while(4'b0011, 2, n);
    checks++;
    if (bus.green !== 4'b0010) begin errors++; $display("FAIL rot_next_grant: got %b expected 0010", bus.green); end
    checks++;
    if (dut_out() !== model_out()) begin errors++; $display("FAIL rot_model: got %h expected %h", dut_out(), model_out()); end
  endtask

  task automatic test_reset_mid_amber();
    int n;
    do_reset();
    step(4'b0000);
    step(4'b0000);
    run_while(4'b0100, 0, n);
    step(4'b0100);
    checks++;
    if (bus.amber !== 4'b0001) begin errors++; $display("FAIL mid_amber_setup: got %b expected 0001", bus.amber); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_out() !== {4'b0000, 4'b0000, 4'b1111, 2'd3}) begin
      errors++;
      $display("FAIL mid_amber_reset: got %h expected %h", dut_out(), {4'b0000, 4'b0000, 4'b1111, 2'd3});
    end
    @(posedge clk); #1 rst = 1'b1;
    step(4'b0100);
    checks++;
    if (bus.red !== 4'b1111) begin errors++; $display("FAIL mid_amber_red: got %b expected 1111", bus.red); end
    step(4'b0100);
    checks++;
    if (bus.green !== 4'b0100) begin errors++; $display("FAIL mid_amber_regrant: got %b expected 0100", bus.green); end
  endtask

`ifdef REST_CYCLE_EN
  task automatic test_rest_cycle();
    int n;
    do_reset();
    step(4'b0000);
    step(4'b0000);
    run_while(4'b0000, 0, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL rest_green_len: got %0d expected 6", n); end
    run_while(4'b0000, 1, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL rest_amber_len: got %0d expected 2", n); end
    run_while(4'b0000, 2, n);
    checks++;
    if (bus.green !== 4'b0010) begin errors++; $display("FAIL rest_next_grant: got %b expected 0010", bus.green); end
  endtask
`endif

  task automatic test_random();
    logic [3:0] r;
    int hold;
    do_reset();
    r = 4'b0000;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        r = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 25);
      end
      hold--;
      step(r);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL random_model cyc%0d: got %h expected %h", i, dut_out(), model_out());
      end
      checks++;
      if ($countones(bus.green | bus.amber) > 1 || (bus.green & bus.amber) != 0) begin
        errors++;
        $display("FAIL random_onehot cyc%0d: got green=%b amber=%b expected at most one lamp", i, bus.green, bus.amber);
      end
      if (i % 1000 == 777) begin
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_min_green();
    test_rotation_max_green();
    test_reset_mid_amber();
`ifdef REST_CYCLE_EN
    test_rest_cycle();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
